// File: rtl/relax_osc_freq_meter.sv
// Multi-channel frequency meter: counts synchronised rising edges of each osc input over a gate window.
// Latency: osc pin to counted edge pulse is SYNC_STAGES+1 clk; done rises G+1 cycles after the start edge.
// Backpressure: none; start is ignored while busy, and results are overwritten by the next window.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ena                 block enable; low forces IDLE and aborts the current window
//   osc_in              raw asynchronous oscillator outputs, one per channel
//   gate_len            gate window length in clk cycles (0 behaves as 1)
//   start, continuous   measurement request / auto re-arm after each result
//   ch_sel              channel shown on count_out (out-of-range selects read as 0)
//   busy, done          measuring-or-latching flag / one-cycle results-valid pulse
//   overflow, count_out per-channel saturation flags / selected channel's latched count
module relax_osc_freq_meter #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 16,
    parameter int GATE_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          ena,
    input  logic [NUM_CH-1:0]                             osc_in,
    input  logic [GATE_W-1:0]                             gate_len,
    input  logic                                          start,
    input  logic                                          continuous,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] ch_sel,
    output logic                                          busy,
    output logic                                          done,
    output logic [NUM_CH-1:0]                             overflow,
    output logic [CNT_W-1:0]                              count_out
);

    typedef enum logic [1:0] {IDLE, MEASURE, LATCH} state_t;

    state_t              state_q, state_d;
    logic                load_gate;
    logic                latch_en;
    logic [GATE_W-1:0]   gate_cnt_q;
    logic [GATE_W-1:0]   gate_eff;
    logic [NUM_CH-1:0]   sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0]   sync_prev_q;
    logic [NUM_CH-1:0]   edge_pls;
    logic [CNT_W-1:0]    cnt_q    [NUM_CH];
    logic [CNT_W-1:0]    result_q [NUM_CH];
    logic [NUM_CH-1:0]   ovf_acc_q;
    logic [NUM_CH-1:0]   overflow_q;
    logic                done_q;

    // Synchroniser chain plus one extra flop to detect the rising edge of the synced level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            sync_prev_q <= '0;
        end else begin
            sync_q[0] <= osc_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            sync_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_pls = sync_q[SYNC_STAGES-1] & ~sync_prev_q;
    assign gate_eff = (gate_len == '0) ? GATE_W'(1) : gate_len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        load_gate = 1'b0;
        latch_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ena && start) begin
                    state_d   = MEASURE;
                    load_gate = 1'b1;
                end
            end
            MEASURE: begin
                if (!ena)                           state_d = IDLE;
                else if (gate_cnt_q == GATE_W'(1))  state_d = LATCH;
            end
            LATCH: begin
                latch_en = ena;
                // Re-arm reloads gate_len live, so each window is followed by one dead cycle.
                if (ena && continuous) begin
                    state_d   = MEASURE;
                    load_gate = 1'b1;
                end else begin
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  gate_cnt_q <= '0;
        else if (load_gate)          gate_cnt_q <= gate_eff;
        else if (state_q == MEASURE) gate_cnt_q <= gate_cnt_q - 1'b1;
    end

    // Edge counters saturate at all-ones; a further edge marks that channel as overflowed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
            ovf_acc_q <= '0;
        end else if (load_gate || !ena) begin
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
            ovf_acc_q <= '0;
        end else if (state_q == MEASURE) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (edge_pls[i]) begin
                    if (cnt_q[i] == {CNT_W{1'b1}}) ovf_acc_q[i] <= 1'b1;
                    else                           cnt_q[i]     <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Results and done are registered together so done marks the first cycle the results are visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) result_q[i] <= '0;
            overflow_q <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= latch_en;
            if (latch_en) begin
                for (int i = 0; i < NUM_CH; i++) result_q[i] <= cnt_q[i];
                overflow_q <= ovf_acc_q;
            end
        end
    end

    always_comb begin
        count_out = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(ch_sel) == i) count_out = result_q[i];
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign overflow = overflow_q;

endmodule
